// File: rtl/serializador_doble_pkg.sv
// serializador_doble_pkg: shared constants and types for the double-width serializer.
//   N           default single-word width (half of the input word)
//   HALF_FIRST  half_sel value of the half emitted first
//   HALF_SECOND half_sel value of the half emitted second
//   COUNT_W     width of the optional completed-word counter
package serializador_doble_pkg;

    localparam int unsigned N       = 16;
    localparam int unsigned COUNT_W = 16;

    localparam logic HALF_FIRST  = 1'b0;
    localparam logic HALF_SECOND = 1'b1;

    // Current-word occupancy: nothing held, first half on the bus, second half on the bus.
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

endpackage

// File: rtl/serializador_doble_if.sv
// serializador_doble_if: valid/ready handshake bundle of the serializer.
//   in_data/in_valid/in_ready       double-width producer side (2N bits)
//   out_data/out_valid/out_ready    single-width consumer side (N bits)
//   out_first                       out_data is the first half of its word
// master = producer/consumer environment, slave = serializer.
interface serializador_doble_if #(
    parameter int unsigned N = 16
) ();

    logic [2*N-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_first;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_first
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_first
    );

endinterface

// File: rtl/serializador_doble_reg_palabra_doble.sv
// reg_palabra_doble: W-bit load-enable register, asynchronous active-high reset to zero.
//   clk, reset  clock and async reset
//   load        capture d on the rising edge
//   d, q        data in / held word
module reg_palabra_doble #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/serializador_doble.sv
// serializador_doble: splits each accepted 2N-bit word into two consecutive N-bit halves.
// A current word plus a one-word pending buffer lets back-to-back words stream at one half
// per cycle without bubbles; in_ready drops only when both buffers are occupied.
//   clk, reset   clock, asynchronous active-high reset
//   bus          handshake bundle (slave modport): in_* producer side, out_* consumer side
//   busy         a current or pending word is held
//   word_count   (only with SERIALIZADOR_CONTEO_EN) words whose second half was accepted
// Parameters: N single-word width, LSB_FIRST = 1 emits D[N-1:0] first, 0 emits D[2N-1:N] first.
module serializador_doble #(
    parameter int unsigned N         = serializador_doble_pkg::N,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    serializador_doble_if.slave   bus,
    output logic                  busy
`ifdef SERIALIZADOR_CONTEO_EN
    ,
    output logic [serializador_doble_pkg::COUNT_W-1:0] word_count
`endif
);

    import serializador_doble_pkg::*;

    localparam int unsigned W2 = 2 * N;

    state_t          state;
    state_t          state_n;
    logic            pend_valid;
    logic            pend_valid_n;
    logic            cur_load;
    logic            pend_load;
    logic            accept;
    logic            fire;
    logic            half_n;
    logic [W2-1:0]   cur_d;
    logic [W2-1:0]   cur_q;
    logic [W2-1:0]   pend_q;
    logic [W2-1:0]   cur_next;

    // Half selection honouring the configured emission order.
    function automatic logic [N-1:0] sel_half(input logic [W2-1:0] w, input logic half);
        if ((half == HALF_FIRST) == LSB_FIRST) begin
            return w[N-1:0];
        end
        return w[W2-1:N];
    endfunction

    reg_palabra_doble #(.W(W2)) u_cur (
        .clk   (clk),
        .reset (reset),
        .load  (cur_load),
        .d     (cur_d),
        .q     (cur_q)
    );

    reg_palabra_doble #(.W(W2)) u_pend (
        .clk   (clk),
        .reset (reset),
        .load  (pend_load),
        .d     (bus.in_data),
        .q     (pend_q)
    );

    // Next-state and buffer-load decode.
    always_comb begin
        state_n      = state;
        pend_valid_n = pend_valid;
        cur_load     = 1'b0;
        pend_load    = 1'b0;
        cur_d        = bus.in_data;
        accept       = bus.in_valid && bus.in_ready;
        fire         = bus.out_valid && bus.out_ready;

        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    cur_load = 1'b1;
                    state_n  = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (fire) begin
                    state_n = ST_SECOND;
                end
                if (accept) begin
                    pend_load    = 1'b1;
                    pend_valid_n = 1'b1;
                end
            end
            ST_SECOND: begin
                if (fire) begin
                    // in_ready is low while pend is full, so drain and accept never coincide.
                    if (pend_valid) begin
                        cur_d        = pend_q;
                        cur_load     = 1'b1;
                        pend_valid_n = 1'b0;
                        state_n      = ST_FIRST;
                    end else if (accept) begin
                        cur_load = 1'b1;
                        state_n  = ST_FIRST;
                    end else begin
                        state_n = ST_EMPTY;
                    end
                end else if (accept) begin
                    pend_load    = 1'b1;
                    pend_valid_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_EMPTY;
            end
        endcase

        cur_next = cur_load ? cur_d : cur_q;
        half_n   = (state_n == ST_SECOND) ? HALF_SECOND : HALF_FIRST;
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_EMPTY;
            pend_valid    <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_data  <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            pend_valid    <= pend_valid_n;
            bus.in_ready  <= !pend_valid_n;
            bus.out_valid <= (state_n != ST_EMPTY);
            bus.out_first <= (state_n == ST_FIRST);
            bus.out_data  <= sel_half(cur_next, half_n);
            busy          <= (state_n != ST_EMPTY) || pend_valid_n;
        end
    end

`ifdef SERIALIZADOR_CONTEO_EN
    // Completed-word counter; wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (fire && (state == ST_SECOND)) begin
            word_count <= word_count + COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_serializador_doble.sv
// tb_serializador_doble: drives two serializers (LSB_FIRST = 1 and 0) with the same stimulus
// and compares them every cycle against a queue-of-halves reference model, plus literal checks.
module tb_serializador_doble;

    typedef struct {
        logic [15:0] d;
        bit          first;
    } half_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        busy0;
    logic        busy1;
`ifdef SERIALIZADOR_CONTEO_EN
    logic [15:0] wc0;
    logic [15:0] wc1;
`endif

    int compared   = 0;
    int mismatched = 0;

    half_t q0[$];
    half_t q1[$];
    int    wcm0 = 0;
    int    wcm1 = 0;
    bit    a0, a1, f0, f1;

    serializador_doble_if #(.N(16)) bus0 ();
    serializador_doble_if #(.N(16)) bus1 ();

    assign bus0.in_data   = in_data;
    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.in_data   = in_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;

    serializador_doble #(.N(16), .LSB_FIRST(1'b1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0),
        .busy  (busy0)
`ifdef SERIALIZADOR_CONTEO_EN
        , .word_count (wc0)
`endif
    );

    serializador_doble #(.N(16), .LSB_FIRST(1'b0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1),
        .busy  (busy1)
`ifdef SERIALIZADOR_CONTEO_EN
        , .word_count (wc1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted word becomes two queued halves; the DUT holds every
    // queued half, so at most two words (four halves) fit and a new word needs <= 2 queued.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            wcm0 = 0;
            wcm1 = 0;
        end else begin
            a0 = in_valid && (q0.size() <= 2);
            a1 = in_valid && (q1.size() <= 2);
            f0 = out_ready && (q0.size() > 0);
            f1 = out_ready && (q1.size() > 0);
            if (f0) begin
                if (!q0[0].first) wcm0 = (wcm0 + 1) % 65536;
                void'(q0.pop_front());
            end
            if (f1) begin
                if (!q1[0].first) wcm1 = (wcm1 + 1) % 65536;
                void'(q1.pop_front());
            end
            if (a0) begin
                q0.push_back('{d: in_data[15:0],  first: 1'b1});
                q0.push_back('{d: in_data[31:16], first: 1'b0});
            end
            if (a1) begin
                q1.push_back('{d: in_data[31:16], first: 1'b1});
                q1.push_back('{d: in_data[15:0],  first: 1'b0});
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("d0_valid", 32'(bus0.out_valid), 32'(q0.size() > 0));
            chk("d0_ready", 32'(bus0.in_ready),  32'(q0.size() <= 2));
            chk("d0_busy",  32'(busy0),          32'(q0.size() > 0));
            if (q0.size() > 0) begin
                chk("d0_data",  32'(bus0.out_data),  32'(q0[0].d));
                chk("d0_first", 32'(bus0.out_first), 32'(q0[0].first));
            end
            chk("d1_valid", 32'(bus1.out_valid), 32'(q1.size() > 0));
            chk("d1_ready", 32'(bus1.in_ready),  32'(q1.size() <= 2));
            chk("d1_busy",  32'(busy1),          32'(q1.size() > 0));
            if (q1.size() > 0) begin
                chk("d1_data",  32'(bus1.out_data),  32'(q1[0].d));
                chk("d1_first", 32'(bus1.out_first), 32'(q1[0].first));
            end
`ifdef SERIALIZADOR_CONTEO_EN
            chk("d0_count", 32'(wc0), 32'(wcm0));
            chk("d1_count", 32'(wc1), 32'(wcm1));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Reset values.
        @(negedge clk);
        chk("rst_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_data",  32'(bus0.out_data),  32'd0);
        chk("rst_first", 32'(bus0.out_first), 32'd0);
        chk("rst_ready", 32'(bus0.in_ready),  32'd1);
        chk("rst_busy",  32'(busy0),          32'd0);
        step();
        reset = 1'b0;
        step();

        // Single word, both emission orders.
        out_ready = 1'b1;
        send_word(32'hBEEF_1234);
        @(negedge clk);
        chk("sw_h0",     32'(bus0.out_data),  32'h1234);
        chk("sw_f0",     32'(bus0.out_first), 32'd1);
        chk("sw_msb_h0", 32'(bus1.out_data),  32'hBEEF);
        @(negedge clk);
        chk("sw_h1", 32'(bus0.out_data),  32'hBEEF);
        chk("sw_f1", 32'(bus0.out_first), 32'd0);
        @(negedge clk);
        chk("sw_idle_valid", 32'(bus0.out_valid), 32'd0);
        chk("sw_idle_busy",  32'(busy0),          32'd0);

        step();
        send_word(32'hAAAA_5555);
        @(negedge clk);
        chk("msb_h0", 32'(bus1.out_data), 32'hAAAA);
        chk("lsb_h0", 32'(bus0.out_data), 32'h5555);
        @(negedge clk);
        chk("msb_h1", 32'(bus1.out_data), 32'h5555);
        step();
        step();

        // Back-to-back words with the consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();

        // Backpressure: fill both buffers, third word blocked, then release.
        out_ready = 1'b0;
        send_word(32'hC0DE_0001);
        send_word(32'hC0DE_0002);
        in_data  = 32'hC0DE_0003;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold",    32'(bus0.out_data), 32'h0001);
            chk("bp_blocked", 32'(bus0.in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        repeat (10) step();

        // Reset in the middle of a word.
        out_ready = 1'b0;
        send_word(32'h1111_2222);
        @(negedge clk);
        chk("mr_h0", 32'(bus0.out_data), 32'h2222);
        #1 reset = 1'b1;
        #1;
        chk("mr_valid", 32'(bus0.out_valid), 32'd0);
        chk("mr_ready", 32'(bus0.in_ready),  32'd1);
        chk("mr_busy",  32'(busy0),          32'd0);
        step();
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        send_word(32'h3333_4444);
        @(negedge clk);
        chk("mr_new_h0", 32'(bus0.out_data), 32'h4444);
        @(negedge clk);
        chk("mr_new_h1", 32'(bus0.out_data), 32'h3333);
        step();

`ifdef SERIALIZADOR_CONTEO_EN
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        repeat (6) step();
        @(negedge clk);
        chk("cnt_three", 32'(wc0), 32'd3);
        step();
        force dut0.word_count = 16'hFFFF;
        force dut1.word_count = 16'hFFFF;
        #1;
        release dut0.word_count;
        release dut1.word_count;
        wcm0 = 16'hFFFF;
        wcm1 = 16'hFFFF;
        send_word(32'h0000_0003);
        repeat (4) step();
        @(negedge clk);
        chk("cnt_wrap", 32'(wc0), 32'd0);
        step();
`endif

        // Randomized traffic with varying consumer throttling.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            case (i / 1000)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) != 0);
                default: out_ready = ($urandom_range(0, 3) == 0);
            endcase
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serializador_doble.md
Name: serializador_doble

Overview:
- Unpacks double-width (2N-bit) words, such as products held in the design's double-width enable registers, into two consecutive N-bit halves.
- Feeds single-width consumers such as the N-bit datapath or output port.
- Valid/ready handshake on both sides.
- One-word pending buffer, so back-to-back words stream at one half per cycle with no bubbles.

Parameters:
- N, 16, single-word width; equals `N from constantes.h.
- LSB_FIRST, 1, 1 = low half D[N-1:0] sent first; 0 = high half D[2N-1:N] first.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  2N  double-width word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  N  current half.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_first  output  1  out_data is the first half of its word.
- busy  output  1  any word held (current or pending).

Behaviour:
- Registers:
  - cur_word (2N) with cur_valid.
  - pend_word (2N) with pend_valid.
  - half_sel (0 = first half, 1 = second half).
- Reset (async, immediate): cur_valid = pend_valid = 0, half_sel = 0, cur_word = pend_word = 0. Resulting outputs: out_valid = 0, out_data = 0, out_first = 0, in_ready = 1, busy = 0.
- Input handshake:
  - in_ready = !pend_valid (registered state only, no combinational path from out_ready).
  - A word is accepted when in_valid && in_ready at the clock edge.
- States (cur_valid, half_sel): EMPTY; FIRST (cur_valid, half_sel = 0); SECOND (cur_valid, half_sel = 1).
- Output:
  - out_valid = cur_valid.
  - out_data is selected from cur_word by half_sel and LSB_FIRST.
  - out_first = cur_valid && !half_sel.
  - out_data is held stable while out_valid && !out_ready.
- Transitions:
  - EMPTY + accept: cur_word <= in_data, go to FIRST. Latency: word accepted at edge t, first half visible after edge t, second half no earlier than t+1.
  - FIRST + out_ready: go to SECOND.
  - SECOND + out_ready, pend_valid = 1: cur_word <= pend_word, pend_valid <= 0, go to FIRST.
  - SECOND + out_ready, pend_valid = 0, accepting: cur_word <= in_data directly, go to FIRST (no bubble).
  - SECOND + out_ready, pend_valid = 0, not accepting: go to EMPTY.
  - Accept while cur_valid and not being refilled this cycle: word goes to pend_word, pend_valid <= 1.
- Simultaneous events:
  - Pending drains to current and a new input lands in pend in the same edge: not possible, since in_ready = 0 whenever pend_valid = 1.
  - Accept while in EMPTY with pend empty: always goes to cur.
- Ordering: words leave in acceptance order. Each word emits exactly two halves; a half is never dropped or duplicated.
- Throughput: sustained one half per cycle with out_ready held high. in_ready deasserts only when both buffers are full.
- busy = cur_valid || pend_valid.
- Reset mid-word discards all held data; no partial word is emitted after reset.

Optional Feature:
- Macro SERIALIZADOR_CONTEO_EN.
- Defined:
  - Adds output word_count (16-bit): count of words whose second half completed its handshake.
  - Resets to 0; wraps 0xFFFF -> 0x0000.
  - Increments the cycle after the second-half handshake.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared constants file (constantes.h): N, plus localparams HALF_FIRST = 1'b0 and HALF_SECOND = 1'b1.
- One natural sub-module: reg_palabra_doble, a 2N-bit load-enable register with async reset. Instantiated twice, for cur_word and pend_word.
- Half-select mux and control stay in the top.

Test Plan:
- Single word: in_data = 0xBEEF_1234 (N = 16, LSB_FIRST = 1), out_ready = 1 -> out_data 0x1234 (out_first = 1), then 0xBEEF (out_first = 0), then out_valid = 0, busy = 0.
- Back-to-back: 4 words on consecutive accepts, out_ready = 1 -> 8 consecutive out_valid cycles with correct halves in order; in_ready never blocks more than one cycle.
- Backpressure: out_ready = 0 for 5 cycles after the first half -> out_data stable. A second word accepted into pend, third word blocked (in_ready = 0). After release, halves arrive in order with none lost.
- LSB_FIRST = 0: 0xAAAA_5555 -> 0xAAAA then 0x5555.
- Reset mid-word: assert reset after the first half of 0x1111_2222 -> out_valid = 0 immediately, in_ready = 1. Next word 0x3333_4444 emits only 0x4444, 0x3333.
- With SERIALIZADOR_CONTEO_EN: 3 full words -> word_count = 3. Counter preloaded to 0xFFFF by forcing, then one word -> 0x0000.
